// File: rtl/mem_stage_pkg.sv
// Shared definitions for the data-memory pipeline stage: op codes, FSM states,
// the MEM latch layout and load/store classification helpers.
package mem_stage_pkg;

  localparam int DBITS   = 32;
  localparam int IOPBITS = 6;

  localparam logic [IOPBITS-1:0] ADD_I = 6'h01;
  localparam logic [IOPBITS-1:0] LW_I  = 6'h20;
  localparam logic [IOPBITS-1:0] LH_I  = 6'h21;
  localparam logic [IOPBITS-1:0] LHU_I = 6'h22;
  localparam logic [IOPBITS-1:0] LB_I  = 6'h23;
  localparam logic [IOPBITS-1:0] LBU_I = 6'h24;
  localparam logic [IOPBITS-1:0] SW_I  = 6'h28;
  localparam logic [IOPBITS-1:0] SH_I  = 6'h29;
  localparam logic [IOPBITS-1:0] SB_I  = 6'h2A;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  // MEM latch handed to writeback, fields in MSB-to-LSB order.
  typedef struct packed {
    logic             valid;
    logic [DBITS-1:0] pc;
    logic [4:0]       dest;
    logic             wr_reg;
    logic [DBITS-1:0] wdata;
    logic             err;
  } mem_latch_t;

  function automatic logic is_load(input logic [IOPBITS-1:0] op);
    return (op == LW_I) || (op == LH_I) || (op == LHU_I) || (op == LB_I) || (op == LBU_I);
  endfunction

  function automatic logic is_store(input logic [IOPBITS-1:0] op);
    return (op == SW_I) || (op == SH_I) || (op == SB_I);
  endfunction

  function automatic logic is_mem(input logic [IOPBITS-1:0] op);
    return is_load(op) || is_store(op);
  endfunction

  function automatic logic is_misaligned(input logic [IOPBITS-1:0] op, input logic [1:0] lo);
    return ((op == LW_I) && (lo != 2'b00)) ||
           (((op == LH_I) || (op == LHU_I) || (op == SH_I)) && lo[0]);
  endfunction

endpackage

// File: rtl/mem_stage_lane_unit.sv
// Combinational lane logic: store byte-enables/replication and load
// sub-word extraction with sign or zero extension.
module mem_lane_unit
  import mem_stage_pkg::*;
(
  input  logic [IOPBITS-1:0] st_op_i,
  input  logic [1:0]         st_addr_lo_i,
  input  logic [DBITS-1:0]   st_data_i,
  output logic [3:0]         st_be_o,
  output logic [DBITS-1:0]   st_wdata_o,
  input  logic [IOPBITS-1:0] ld_op_i,
  input  logic [1:0]         ld_addr_lo_i,
  input  logic [DBITS-1:0]   ld_rdata_i,
  output logic [DBITS-1:0]   ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be_o    = 4'b0000;
    st_wdata_o = '0;
    case (st_op_i)
      SB_I: begin
        st_be_o    = 4'b0001 << st_addr_lo_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      SH_I: begin
        st_be_o    = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      SW_I: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
      end
      default: ;
    endcase
  end

  // Halves select on addr[1] only, so a misaligned half reads the containing half.
  always_comb begin
    ld_byte   = ld_rdata_i[{ld_addr_lo_i, 3'b000} +: 8];
    ld_half   = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    ld_data_o = '0;
    case (ld_op_i)
      LB_I:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      LBU_I:   ld_data_o = {24'h000000, ld_byte};
      LH_I:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      LHU_I:   ld_data_o = {16'h0000, ld_half};
      LW_I:    ld_data_o = ld_rdata_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Data-memory pipeline stage with req/ack port, access timeout and hazard info.
// Optional MEM_ALIGN_CHECK_EN: misaligned LW/LH/LHU/SH complete at once with mem_err.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DBITS          = 32,
  parameter int IOPBITS        = 6,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               agex_valid,
  input  logic [IOPBITS-1:0] agex_op,
  input  logic [DBITS-1:0]   agex_pc,
  input  logic [4:0]         agex_dest,
  input  logic               agex_wr_reg,
  input  logic [DBITS-1:0]   agex_result,
  input  logic [DBITS-1:0]   agex_mem_addr,
  output logic               stall_to_agex,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DBITS-1:0]   dmem_addr,
  output logic [DBITS-1:0]   dmem_wdata,
  output logic [3:0]         dmem_be,
  input  logic               dmem_ack,
  input  logic [DBITS-1:0]   dmem_rdata,
  output logic               mem_valid,
  output logic [DBITS-1:0]   mem_pc,
  output logic [4:0]         mem_dest,
  output logic               mem_wr_reg,
  output logic [DBITS-1:0]   mem_wdata_reg,
  output logic               mem_err,
  output logic [4:0]         fwd_dest,
  output logic               fwd_busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DBITS-1:0]   req_addr_q, req_wdata_q, req_pc_q;
  logic [3:0]         req_be_q;
  logic [IOPBITS-1:0] req_op_q;
  logic [4:0]         req_dest_q;
  logic               req_wr_q;
  logic [1:0]         req_lo_q;
  mem_latch_t         mem_q, mem_d;

  logic [3:0]         st_be;
  logic [DBITS-1:0]   st_wdata, ld_data;
  logic               misalign, accept_mem, timeout_hit;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = is_misaligned(agex_op, agex_mem_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign accept_mem  = (state_q == S_IDLE) && agex_valid && is_mem(agex_op) && !misalign;
  assign timeout_hit = (state_q == S_WAIT) && !dmem_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  mem_lane_unit u_lane (
    .st_op_i      (agex_op),
    .st_addr_lo_i (agex_mem_addr[1:0]),
    .st_data_i    (agex_result),
    .st_be_o      (st_be),
    .st_wdata_o   (st_wdata),
    .ld_op_i      (req_op_q),
    .ld_addr_lo_i (req_lo_q),
    .ld_rdata_i   (dmem_rdata),
    .ld_data_o    (ld_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // An ack on the final allowed cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept_mem) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dmem_ack || timeout_hit) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    stall_to_agex = 1'b0;
    fwd_dest      = agex_dest;
    fwd_busy      = 1'b0;
    mem_d         = '0;
    case (state_q)
      S_IDLE: begin
        stall_to_agex = accept_mem;
        fwd_busy      = accept_mem && is_load(agex_op) && agex_wr_reg;
        if (agex_valid && !is_mem(agex_op)) begin
          mem_d.valid  = 1'b1;
          mem_d.pc     = agex_pc;
          mem_d.dest   = agex_dest;
          mem_d.wr_reg = agex_wr_reg;
          mem_d.wdata  = agex_result;
        end else if (agex_valid && misalign) begin
          mem_d.valid = 1'b1;
          mem_d.pc    = agex_pc;
          mem_d.dest  = agex_dest;
          mem_d.err   = 1'b1;
        end
      end
      S_WAIT: begin
        dmem_req      = 1'b1;
        dmem_we       = is_store(req_op_q);
        stall_to_agex = 1'b1;
        fwd_dest      = req_dest_q;
        fwd_busy      = is_load(req_op_q) && req_wr_q;
        if (dmem_ack) begin
          mem_d.valid  = 1'b1;
          mem_d.pc     = req_pc_q;
          mem_d.dest   = req_dest_q;
          mem_d.wr_reg = is_load(req_op_q) && req_wr_q;
          mem_d.wdata  = is_load(req_op_q) ? ld_data : '0;
        end else if (timeout_hit) begin
          mem_d.valid = 1'b1;
          mem_d.pc    = req_pc_q;
          mem_d.dest  = req_dest_q;
          mem_d.err   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_pc_q    <= '0;
      req_be_q    <= 4'b0000;
      req_op_q    <= '0;
      req_dest_q  <= '0;
      req_wr_q    <= 1'b0;
      req_lo_q    <= 2'b00;
    end else if (accept_mem) begin
      req_addr_q  <= {agex_mem_addr[DBITS-1:2], 2'b00};
      req_wdata_q <= st_wdata;
      req_pc_q    <= agex_pc;
      req_be_q    <= st_be;
      req_op_q    <= agex_op;
      req_dest_q  <= agex_dest;
      req_wr_q    <= agex_wr_reg;
      req_lo_q    <= agex_mem_addr[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mem_q <= '0;
    else        mem_q <= mem_d;
  end

  assign dmem_addr     = req_addr_q;
  assign dmem_wdata    = req_wdata_q;
  assign dmem_be       = req_be_q;
  assign mem_valid     = mem_q.valid;
  assign mem_pc        = mem_q.pc;
  assign mem_dest      = mem_q.dest;
  assign mem_wr_reg    = mem_q.wr_reg;
  assign mem_wdata_reg = mem_q.wdata;
  assign mem_err       = mem_q.err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboard of expected MEM latches popped on mem_valid.
// Honours MEM_ALIGN_CHECK_EN for the misaligned-LW case.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        agex_valid;
  logic [5:0]  agex_op;
  logic [31:0] agex_pc;
  logic [4:0]  agex_dest;
  logic        agex_wr_reg;
  logic [31:0] agex_result;
  logic [31:0] agex_mem_addr;
  logic        stall_to_agex;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic [4:0]  mem_dest;
  logic        mem_wr_reg;
  logic [31:0] mem_wdata_reg;
  logic        mem_err;
  logic [4:0]  fwd_dest;
  logic        fwd_busy;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        wr;
    logic [31:0] wdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   req_cycles;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .reset         (reset),
    .agex_valid    (agex_valid),
    .agex_op       (agex_op),
    .agex_pc       (agex_pc),
    .agex_dest     (agex_dest),
    .agex_wr_reg   (agex_wr_reg),
    .agex_result   (agex_result),
    .agex_mem_addr (agex_mem_addr),
    .stall_to_agex (stall_to_agex),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_be       (dmem_be),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .mem_valid     (mem_valid),
    .mem_pc        (mem_pc),
    .mem_dest      (mem_dest),
    .mem_wr_reg    (mem_wr_reg),
    .mem_wdata_reg (mem_wdata_reg),
    .mem_err       (mem_err),
    .fwd_dest      (fwd_dest),
    .fwd_busy      (fwd_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [31:0] pc,
                               input logic [4:0] dest, input logic wr, input logic [31:0] res,
                               input logic [31:0] addr);
    agex_valid    = v;
    agex_op       = op;
    agex_pc       = pc;
    agex_dest     = dest;
    agex_wr_reg   = wr;
    agex_result   = res;
    agex_mem_addr = addr;
  endtask

  task automatic pushExp(input logic [31:0] pc, input logic [4:0] dest, input logic wr,
                         input logic [31:0] wdata, input logic err);
    exp_t e;
    e.pc = pc; e.dest = dest; e.wr = wr; e.wdata = wdata; e.err = err;
    sb.push_back(e);
  endtask

  // Called right after a memory op is driven; drives the ack after noAck idle WAIT cycles.
  task automatic memAccess(input string tag, input int noAck, input logic [31:0] rdata,
                           input logic [31:0] expAddr, input logic [3:0] expBe,
                           input logic [31:0] expWd, input logic expWe,
                           input logic [4:0] expDest, input logic expBusy);
    int stalls = 0;
    @(negedge clk);
    if (stall_to_agex) stalls++;
    checkOutput({tag, "_req_at_accept"}, dmem_req, 1'b0);
    checkOutput({tag, "_fwd_busy_accept"}, fwd_busy, expBusy);
    tick();
    agex_valid = 1'b0;
    agex_dest  = 5'd31;
    for (int i = 0; i <= noAck; i++) begin
      if (i == noAck) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
      end
      @(negedge clk);
      if (stall_to_agex) stalls++;
      if (i == 0) begin
        checkOutput({tag, "_req"}, dmem_req, 1'b1);
        checkOutput({tag, "_we"}, dmem_we, expWe);
        checkOutput({tag, "_addr"}, dmem_addr, expAddr);
        checkOutput({tag, "_fwd_dest"}, fwd_dest, expDest);
        checkOutput({tag, "_fwd_busy"}, fwd_busy, expBusy);
        if (expWe) begin
          checkOutput({tag, "_be"}, dmem_be, expBe);
          checkOutput({tag, "_wdata"}, dmem_wdata, expWd);
        end
      end
      tick();
    end
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    @(negedge clk);
    checkOutput({tag, "_req_after_ack"}, dmem_req, 1'b0);
    checkOutput({tag, "_stall_cycles"}, stalls, noAck + 2);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && mem_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_mem_valid", mem_valid, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("mem_pc", mem_pc, mon_e.pc);
        checkOutput("mem_dest", mem_dest, mon_e.dest);
        checkOutput("mem_wr_reg", mem_wr_reg, mon_e.wr);
        checkOutput("mem_err", mem_err, mon_e.err);
        if (mon_e.wr) checkOutput("mem_wdata_reg", mem_wdata_reg, mon_e.wdata);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    applyStimulus(1'b0, 6'h00, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
    #3;
    checkOutput("rst_dmem_req", dmem_req, 1'b0);
    checkOutput("rst_dmem_we", dmem_we, 1'b0);
    checkOutput("rst_mem_valid", mem_valid, 1'b0);
    checkOutput("rst_mem_err", mem_err, 1'b0);
    checkOutput("rst_mem_wr_reg", mem_wr_reg, 1'b0);
    checkOutput("rst_mem_wdata", mem_wdata_reg, 32'h0);
    checkOutput("rst_dmem_addr", dmem_addr, 32'h0);
    #9;
    reset = 1'b1;

    // Non-memory op: one-cycle pass-through.
    tick();
    applyStimulus(1'b1, ADD_I, 32'h40, 5'd5, 1'b1, 32'h0000_1234, 32'h0);
    pushExp(32'h40, 5'd5, 1'b1, 32'h0000_1234, 1'b0);
    @(negedge clk);
    checkOutput("add_stall", stall_to_agex, 1'b0);
    checkOutput("add_req", dmem_req, 1'b0);
    checkOutput("add_fwd_dest", fwd_dest, 32'd5);
    tick();
    agex_valid = 1'b0;
    @(negedge clk);
    checkOutput("add_req_after", dmem_req, 1'b0);
    tick();
    @(negedge clk);
    checkOutput("bubble_mem_valid", mem_valid, 1'b0);

    tick();
    applyStimulus(1'b1, LB_I, 32'h44, 5'd6, 1'b1, 32'h0, 32'h0000_0103);
    pushExp(32'h44, 5'd6, 1'b1, 32'hFFFF_FF80, 1'b0);
    memAccess("lb", 2, 32'h80FF_FFFF, 32'h100, 4'b0000, 32'h0, 1'b0, 5'd6, 1'b1);

    tick();
    applyStimulus(1'b1, SH_I, 32'h48, 5'd3, 1'b1, 32'h0000_ABCD, 32'h0000_0202);
    pushExp(32'h48, 5'd3, 1'b0, 32'h0, 1'b0);
    memAccess("sh", 0, 32'h0, 32'h200, 4'b1100, 32'hABCD_ABCD, 1'b1, 5'd3, 1'b0);

    tick();
    applyStimulus(1'b1, SB_I, 32'h4C, 5'd0, 1'b0, 32'h1234_565A, 32'h0000_0301);
    pushExp(32'h4C, 5'd0, 1'b0, 32'h0, 1'b0);
    memAccess("sb", 1, 32'h0, 32'h300, 4'b0010, 32'h5A5A_5A5A, 1'b1, 5'd0, 1'b0);

    tick();
    applyStimulus(1'b1, SW_I, 32'h50, 5'd0, 1'b0, 32'hCAFE_F00D, 32'h0000_030C);
    pushExp(32'h50, 5'd0, 1'b0, 32'h0, 1'b0);
    memAccess("sw", 0, 32'h0, 32'h30C, 4'b1111, 32'hCAFE_F00D, 1'b1, 5'd0, 1'b0);

    tick();
    applyStimulus(1'b1, LH_I, 32'h54, 5'd7, 1'b1, 32'h0, 32'h0000_0102);
    pushExp(32'h54, 5'd7, 1'b1, 32'hFFFF_8001, 1'b0);
    memAccess("lh", 1, 32'h8001_1234, 32'h100, 4'b0000, 32'h0, 1'b0, 5'd7, 1'b1);

    tick();
    applyStimulus(1'b1, LHU_I, 32'h58, 5'd8, 1'b1, 32'h0, 32'h0000_0102);
    pushExp(32'h58, 5'd8, 1'b1, 32'h0000_8001, 1'b0);
    memAccess("lhu", 0, 32'h8001_1234, 32'h100, 4'b0000, 32'h0, 1'b0, 5'd8, 1'b1);

    tick();
    applyStimulus(1'b1, LBU_I, 32'h5C, 5'd10, 1'b1, 32'h0, 32'h0000_0101);
    pushExp(32'h5C, 5'd10, 1'b1, 32'h0000_00F0, 1'b0);
    memAccess("lbu", 0, 32'h0000_F000, 32'h100, 4'b0000, 32'h0, 1'b0, 5'd10, 1'b1);

    tick();
    applyStimulus(1'b1, LW_I, 32'h60, 5'd11, 1'b1, 32'h0, 32'h0000_0108);
    pushExp(32'h60, 5'd11, 1'b1, 32'hDEAD_BEEF, 1'b0);
    memAccess("lw", 0, 32'hDEAD_BEEF, 32'h108, 4'b0000, 32'h0, 1'b0, 5'd11, 1'b1);

    // Timeout: no ack ever, request must stay up exactly TIMEOUT_CYCLES cycles.
    tick();
    applyStimulus(1'b1, LW_I, 32'h64, 5'd12, 1'b1, 32'h0, 32'h0000_0110);
    pushExp(32'h64, 5'd12, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    tick();
    agex_valid = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dmem_req !== 1'b1) break;
      req_cycles++;
      tick();
    end
    checkOutput("timeout_req_cycles", req_cycles, 32'd15);
    checkOutput("timeout_mem_err", mem_err, 1'b1);

    tick();
    applyStimulus(1'b1, LW_I, 32'h68, 5'd13, 1'b1, 32'h0, 32'h0000_0114);
    pushExp(32'h68, 5'd13, 1'b1, 32'h0102_0304, 1'b0);
    memAccess("lw_ack15", 14, 32'h0102_0304, 32'h114, 4'b0000, 32'h0, 1'b0, 5'd13, 1'b1);

    // Reset in the middle of an access: request must drop without waiting for a clock.
    tick();
    applyStimulus(1'b1, LW_I, 32'h6C, 5'd2, 1'b1, 32'h0, 32'h0000_0120);
    @(negedge clk);
    tick();
    agex_valid = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_req_before", dmem_req, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("rstmid_req", dmem_req, 1'b0);
    checkOutput("rstmid_mem_valid", mem_valid, 1'b0);
    checkOutput("rstmid_stall", stall_to_agex, 1'b0);
    tick();
    checkOutput("rstmid_req_held", dmem_req, 1'b0);
    reset = 1'b1;
    tick();
    applyStimulus(1'b1, ADD_I, 32'h70, 5'd14, 1'b1, 32'h5555_AAAA, 32'h0);
    pushExp(32'h70, 5'd14, 1'b1, 32'h5555_AAAA, 1'b0);
    @(negedge clk);
    checkOutput("post_rst_add_req", dmem_req, 1'b0);
    tick();
    agex_valid = 1'b0;
    @(negedge clk);

`ifdef MEM_ALIGN_CHECK_EN
    tick();
    applyStimulus(1'b1, LW_I, 32'h80, 5'd9, 1'b1, 32'h0, 32'h0000_0101);
    pushExp(32'h80, 5'd9, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("misalign_stall", stall_to_agex, 1'b0);
    checkOutput("misalign_req", dmem_req, 1'b0);
    tick();
    agex_valid = 1'b0;
    @(negedge clk);
    checkOutput("misalign_req_after", dmem_req, 1'b0);
    checkOutput("misalign_err", mem_err, 1'b1);
`else
    tick();
    applyStimulus(1'b1, LW_I, 32'h80, 5'd9, 1'b1, 32'h0, 32'h0000_0101);
    pushExp(32'h80, 5'd9, 1'b1, 32'h1122_3344, 1'b0);
    memAccess("lw_unaligned", 0, 32'h1122_3344, 32'h100, 4'b0000, 32'h0, 1'b0, 5'd9, 1'b1);
`endif

    tick();
    @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of address-generate/execute: consumes its latch (op, result, mem_addr, dest, wr_reg) and performs data-memory access over a multi-cycle req/ack port.
- Produces the MEM latch consumed by writeback.
- Produces forwarding/hazard info and a stall back to execute while an access is outstanding.
- Load sub-word extraction and store byte-enables live here.

Parameters:
- DBITS, 32, data/address width.
- IOPBITS, 6, width of decoded op code (matches shared op-code defines).
- TIMEOUT_CYCLES, 15, max cycles to wait for dmem_ack before abandoning the access.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- agex_valid  in  1  execute latch holds a real instruction
- agex_op  in  IOPBITS  decoded op (LW/LH/LHU/LB/LBU/SW/SH/SB, others pass through)
- agex_pc  in  DBITS  instruction PC
- agex_dest  in  5  destination register
- agex_wr_reg  in  1  instruction writes rd
- agex_result  in  DBITS  ALU result, or store data for stores
- agex_mem_addr  in  DBITS  effective address
- stall_to_agex  out  1  hold execute latch
- dmem_req  out  1  access request
- dmem_we  out  1  write request
- dmem_addr  out  DBITS  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  DBITS  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  access complete; rdata valid this cycle
- dmem_rdata  in  DBITS  read word
- mem_valid  out  1  MEM latch valid
- mem_pc  out  DBITS  PC
- mem_dest  out  5  destination
- mem_wr_reg  out  1  register write enable (0 for stores)
- mem_wdata_reg  out  DBITS  value to write back
- mem_err  out  1  access timed out (or misaligned, see option)
- fwd_dest  out  5  dest of instruction currently in this stage
- fwd_busy  out  1  in-flight load; dest not yet available

Behaviour:
- Reset (reset=0, async): state IDLE, wait counter 0. dmem_req, dmem_we, mem_valid, mem_wr_reg, mem_err = 0. All data outputs = 0.
- States:
  - IDLE: accepts agex_valid.
    - Non-memory op: latched into MEM outputs next edge (1-cycle latency); mem_wdata_reg = agex_result.
    - Memory op: captures addr/be/wdata/op/dest into request regs, goes to WAIT, mem_valid=0 next cycle.
  - WAIT: dmem_req=1, dmem_we=1 for stores. Request signals held stable until ack.
    - On dmem_ack: load → mem_wdata_reg = extracted lane (LB/LH sign-extend; LBU/LHU zero-extend; LW whole word), mem_wr_reg = captured wr_reg; store → mem_wr_reg=0. mem_valid=1 next edge; return to IDLE. dmem_req drops the edge after ack.
    - Counter increments each WAIT cycle without ack. Reaching TIMEOUT_CYCLES: drop req, emit mem_valid=1, mem_err=1, mem_wr_reg=0, return to IDLE.
    - Ack in the same cycle the counter hits the limit: ack wins, no error.
- Minimum load/store latency: accept edge + 1 WAIT cycle with immediate ack → result valid 2 edges after accept.
- stall_to_agex = (state==WAIT) OR (state==IDLE AND agex_valid AND memory op). Execute holds its latch while asserted. A new instruction is accepted the cycle after ack returns the FSM to IDLE.
- agex_valid=0 in IDLE: mem_valid=0 next edge (bubble).
- Store lanes: SB replicates byte ×4, be = 1<<addr[1:0]. SH replicates half ×2, be = addr[1]?4'b1100:4'b0011. SW be=4'b1111.
- fwd_dest = captured dest in WAIT, else agex_dest. fwd_busy = 1 in WAIT for loads with wr_reg=1, or in IDLE when accepting such a load.
- Reset mid-access: request dropped asynchronously, in-flight op lost, no MEM output.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: LW with addr[1:0]!=0, or LH/LHU/SH with addr[0]=1, never enters WAIT and issues no dmem_req. Emits mem_valid=1, mem_err=1, mem_wr_reg=0 next edge.
- Undefined: low address bits are ignored for alignment (LW uses word address; halves use addr[1]), and no error is generated.

Decomposition:
- Shared package/define file: op codes (LW_I…SB_I), DBITS, MEM latch width/field order, FSM state encoding, is_load/is_store helper constants.
- One sub-module: mem_lane_unit (combinational store byte-enable/replication and load extract/extend).

Test Plan:
- ADD result 0x0000_1234, dest 5 in IDLE → next edge mem_valid=1, mem_wdata_reg=0x1234, mem_dest=5, mem_wr_reg=1, no dmem_req.
- LB addr 0x103, ack after 3 cycles with rdata 0x80FF_FFFF → stall_to_agex high 4 cycles, mem_wdata_reg=0xFFFF_FF80, dmem_addr=0x100.
- SH addr 0x202, data 0x0000_ABCD, ack immediate → dmem_be=4'b1100, dmem_wdata=0xABCD_ABCD, dmem_we=1, mem_wr_reg=0.
- LW with no ack for 15 cycles → req drops, mem_valid=1, mem_err=1, mem_wr_reg=0; ack on cycle 15 instead → normal completion, mem_err=0.
- Assert reset low mid-WAIT → dmem_req=0 immediately, mem_valid=0; after release the next ADD completes normally.
- With MEM_ALIGN_CHECK_EN, LW addr 0x101 → no dmem_req, mem_err=1 next edge; without macro → dmem_addr=0x100 read performed.
